// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared FSM state type and counter width helper for the pooling controller
package cim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2
  } pool_state_t;

  // Width needed to count 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_pos_cnt.sv
// rtl/pool_pos_cnt.sv - row/col position and stride-phase tracking for the pooling window
module pool_pos_cnt
  import cim_pkg::*;
#(
  parameter int img_width  = 13,
  parameter int kernel_dim = 3,
  parameter int stride     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output logic win,
  output logic last
);

  localparam int CW = cnt_width(img_width);
  localparam int PW = cnt_width(stride);
  localparam logic [CW-1:0] POS_MAX = CW'(img_width - 1);
  localparam logic [CW-1:0] WIN_MIN = CW'(kernel_dim - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(stride - 1);

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [PW-1:0] row_ph;
  logic [PW-1:0] col_ph;
  logic          col_wrap;

  assign col_wrap = (col == POS_MAX);
  assign last     = col_wrap && (row == POS_MAX);
  // Phase is (pos - (kernel_dim-1)) mod stride, held at zero until the first full window
  assign win      = (row >= WIN_MIN) && (col >= WIN_MIN) && (row_ph == '0) && (col_ph == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
    end else if (adv) begin
      if (col_wrap) begin
        col    <= '0;
        col_ph <= '0;
        if (row == POS_MAX) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + 1'b1;
          if (row >= WIN_MIN) row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (col >= WIN_MIN) col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - pooling layer handshake controller: pixel accept, window emit, end-of-image
module pool_ctrl
  import cim_pkg::*;
#(
  parameter int img_width  = 13,
  parameter int kernel_dim = 3,
  parameter int stride     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_ibuf_we,
  input  logic i_next_busy,
  output logic o_next_start,
  output logic o_done
);

  if (kernel_dim > img_width || stride < 1 || kernel_dim < 1) begin : g_bad_params
    $error("pool_ctrl: kernel_dim/stride invalid for img_width");
  end

  pool_state_t state;
  pool_state_t state_nxt;
  logic        accept;
  logic        win;
  logic        last;
  logic        done_pend;

  // Gated by rst so the buffer write enable drops the moment reset asserts
  assign accept    = i_start && rst && (state == ST_IDLE);
  assign o_ibuf_we = accept;

  pool_pos_cnt #(
    .img_width (img_width),
    .kernel_dim(kernel_dim),
    .stride    (stride)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .adv (accept),
    .win (win),
    .last(last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_busy       = 1'b1;
    o_next_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (accept && win) state_nxt = ST_EMIT;
      end
      ST_EMIT, ST_WAIT: begin
        if (!i_next_busy) begin
          o_next_start = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A producing last pixel reports done with its window; otherwise one cycle after accept
  assign o_done = done_pend && ((state == ST_IDLE) || o_next_start);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                done_pend <= 1'b0;
    else if (accept && last) done_pend <= 1'b1;
    else if (o_done)         done_pend <= 1'b0;
  end

endmodule
